// File: rtl/isp_awb_pkg.sv
// Shared white-balance definitions: Bayer pattern codes, colour indices, gain format.
package isp_awb_pkg;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } bayer_pat_e;

  // Colour index = pattern ^ {row[0], col[0]}
  localparam logic [1:0] CIDX_R  = 2'd0;
  localparam logic [1:0] CIDX_G0 = 2'd1;
  localparam logic [1:0] CIDX_G1 = 2'd2;
  localparam logic [1:0] CIDX_B  = 2'd3;

  localparam logic [7:0] GAIN_ONE   = 8'd128;
  localparam int         GAIN_FRAC  = 7;
  localparam int         ROUND_HALF = 64;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } gain_t;

endpackage

// File: rtl/gain_mul_sat.sv
// Stage 2: pixel * Q1.7 gain, round half up, saturate to 8 bits, one register.
module gain_mul_sat
  import isp_awb_pkg::*;
#(
  parameter int GAIN_FRAC = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_i,
  input  logic [7:0] gain_i,
  input  logic       vld_i,
  output logic [7:0] pix_o,
  output logic       vld_o
);

  logic [15:0] prod;
  logic [16:0] rnd;
  logic [16:0] shf;
  logic [7:0]  pix_d, pix_q;
  logic        vld_q;

  // Multiply, add half an LSB, drop the fraction, clamp at 255
  always_comb begin
    prod  = 16'(pix_i) * 16'(gain_i);
    rnd   = {1'b0, prod} + 17'(ROUND_HALF);
    shf   = rnd >> GAIN_FRAC;
    pix_d = (shf > 17'd255) ? 8'hFF : shf[7:0];
  end

  // Output register; data only moves with a valid pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/bayer_gain_apply.sv
// White-balance gain stage: frame counters, frame-boundary gain commit, colour
// select (stage 1) feeding a multiply/round/saturate register (stage 2).
module bayer_gain_apply
  import isp_awb_pkg::*;
#(
  parameter int GAIN_FRAC = 7,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic [7:0]       din,
  input  logic [1:0]       bayer_pattern,
  input  logic [CNT_W-1:0] h_active_in,
  input  logic [CNT_W-1:0] v_active_in,
  input  logic [7:0]       r_gain_in,
  input  logic [7:0]       g_gain_in,
  input  logic [7:0]       b_gain_in,
  input  logic             gain_en,
  input  logic             bypass,
  output logic [7:0]       dout,
  output logic             dout_en,
  output logic             dout_sof,
  output logic             dout_eol,
  output logic             gain_pending
);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] h_act_q, h_act_d, v_act_q, v_act_d;
  bayer_pat_e       pat_q, pat_d;
  logic             byp_q, byp_d;
  gain_t            act_q, act_d, pend_q, pend_d, gain_in;
  logic             pend_vld_q, pend_vld_d;
  logic             fs, h_last, v_last;
  logic [1:0]       cidx;
  logic [7:0]       gsel;

  // Stage 1 pipeline registers
  logic       vld1_q, sof1_q, eol1_q;
  logic [7:0] pix1_q, gain1_q;
  // Stage 2 flag registers (data/valid live in gain_mul_sat)
  logic       sof2_q, eol2_q;

  // Frame-start commit, gain capture, colour select and counter advance.
  // The _d values of the active registers are what this pixel uses, so a
  // commit on the frame-start cycle already applies to pixel (0,0).
  always_comb begin
    gain_in    = {r_gain_in, g_gain_in, b_gain_in};
    fs         = clken && (h_cnt_q == '0) && (v_cnt_q == '0);
    h_act_d    = h_act_q;
    v_act_d    = v_act_q;
    pat_d      = pat_q;
    byp_d      = byp_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (gain_en) begin
      pend_d     = gain_in;
      pend_vld_d = 1'b1;
    end
    if (fs) begin
      h_act_d    = h_active_in;
      v_act_d    = v_active_in;
      pat_d      = bayer_pat_e'(bayer_pattern);
      byp_d      = bypass;
      if (gain_en)         act_d = gain_in;
      else if (pend_vld_q) act_d = pend_q;
      pend_vld_d = 1'b0;
    end

    cidx = pat_d ^ {v_cnt_q[0], h_cnt_q[0]};
    case (cidx)
      CIDX_R:  gsel = act_d.r;
      CIDX_B:  gsel = act_d.b;
      default: gsel = act_d.g;
    endcase
    if (byp_d) gsel = GAIN_ONE;

    // >= rather than == so a shrunk frame size can't strand the counters
    h_last  = h_cnt_q >= (h_act_d - CNT_W'(1));
    v_last  = v_cnt_q >= (v_act_d - CNT_W'(1));
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (clken) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame state: counters, active/pending gains, latched frame config
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      h_act_q    <= '0;
      v_act_q    <= '0;
      pat_q      <= PAT_RGGB;
      byp_q      <= 1'b0;
      act_q      <= {GAIN_ONE, GAIN_ONE, GAIN_ONE};
      pend_q     <= {GAIN_ONE, GAIN_ONE, GAIN_ONE};
      pend_vld_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      h_act_q    <= h_act_d;
      v_act_q    <= v_act_d;
      pat_q      <= pat_d;
      byp_q      <= byp_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // Stage 1 register: pixel, selected gain and position flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      pix1_q  <= '0;
      gain1_q <= '0;
      sof1_q  <= 1'b0;
      eol1_q  <= 1'b0;
    end else begin
      vld1_q <= clken;
      if (clken) begin
        pix1_q  <= din;
        gain1_q <= gsel;
        sof1_q  <= fs;
        eol1_q  <= h_last;
      end
    end
  end

  // Stage 2 flags, qualified so they only ever pulse with dout_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
    end else begin
      sof2_q <= vld1_q & sof1_q;
      eol2_q <= vld1_q & eol1_q;
    end
  end

  gain_mul_sat #(.GAIN_FRAC(GAIN_FRAC)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .pix_i  (pix1_q),
    .gain_i (gain1_q),
    .vld_i  (vld1_q),
    .pix_o  (dout),
    .vld_o  (dout_en)
  );

  assign dout_sof     = sof2_q;
  assign dout_eol     = eol2_q;
  assign gain_pending = pend_vld_q;

endmodule

// File: tb/tb_bayer_gain_apply.sv
// Directed bench for bayer_gain_apply: hand-computed outputs per frame.
module tb_bayer_gain_apply;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b0;
  logic [7:0]  din = '0;
  logic [1:0]  bayer_pattern = 2'd0;
  logic [10:0] h_active_in = 11'd4;
  logic [10:0] v_active_in = 11'd2;
  logic [7:0]  r_gain_in = 8'd128, g_gain_in = 8'd128, b_gain_in = 8'd128;
  logic        gain_en = 1'b0;
  logic        bypass = 1'b0;
  logic [7:0]  dout;
  logic        dout_en, dout_sof, dout_eol, gain_pending;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } out_t;

  out_t oq[$];
  int   exp_q[$];

  bayer_gain_apply dut (
    .clk           (clk),
    .rst           (rst),
    .clken         (clken),
    .din           (din),
    .bayer_pattern (bayer_pattern),
    .h_active_in   (h_active_in),
    .v_active_in   (v_active_in),
    .r_gain_in     (r_gain_in),
    .g_gain_in     (g_gain_in),
    .b_gain_in     (b_gain_in),
    .gain_en       (gain_en),
    .bypass        (bypass),
    .dout          (dout),
    .dout_en       (dout_en),
    .dout_sof      (dout_sof),
    .dout_eol      (dout_eol),
    .gain_pending  (gain_pending)
  );

  always #5 clk = ~clk;

  // Capture every valid output away from the active edge
  always @(negedge clk) begin
    if (dout_en === 1'b1) oq.push_back({dout, dout_sof, dout_eol});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic px(input logic [7:0] d, input logic ge);
    @(negedge clk);
    clken   = 1'b1;
    din     = d;
    gain_en = ge;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clken   = 1'b0;
      gain_en = 1'b0;
    end
  endtask

  // Drain the pipe, then compare captured outputs with exp_q for a frame of width w
  task automatic chk_frame(input string tag, input int w);
    int   n;
    out_t o;
    idle(4);
    n = exp_q.size();
    chk({tag, "_cnt"}, 16'(oq.size()), 16'(n));
    for (int i = 0; i < n; i++) begin
      if (oq.size() == 0) break;
      o = oq.pop_front();
      chk($sformatf("%s_d%0d", tag, i), 16'(o.d), 16'(exp_q[i]));
      chk($sformatf("%s_sof%0d", tag, i), 16'(o.s), 16'(i == 0));
      chk($sformatf("%s_eol%0d", tag, i), 16'(o.e), 16'((i % w) == (w - 1)));
    end
    exp_q.delete();
    oq.delete();
  endtask

  initial begin
    logic [7:0] rd;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dout", 16'(dout), 16'd0);
    chk("rst_en", 16'(dout_en), 16'd0);
    chk("rst_sof", 16'(dout_sof), 16'd0);
    chk("rst_eol", 16'(dout_eol), 16'd0);
    chk("rst_pend", 16'(gain_pending), 16'd0);
    rst = 1'b0;

    // Frame 1: RGGB 4x2, gains captured while idle, committed at frame start
    @(negedge clk);
    r_gain_in = 8'd192; g_gain_in = 8'd128; b_gain_in = 8'd64;
    gain_en = 1'b1;
    @(negedge clk);
    gain_en = 1'b0;
    chk("f1_pend_before", 16'(gain_pending), 16'd1);
    px(8'd100, 1'b0);
    px(8'd100, 1'b0);
    chk("f1_pend_after", 16'(gain_pending), 16'd0);
    repeat (6) px(8'd100, 1'b0);
    exp_q = '{150, 100, 150, 100, 100, 50, 100, 50};
    chk_frame("rggb", 4);

    // Frame 2: GRBG, din=200, R sites saturate, B sites at 64
    bayer_pattern = 2'd1;
    repeat (8) px(8'd200, 1'b0);
    exp_q = '{200, 255, 200, 255, 100, 200, 100, 200};
    chk_frame("grbg", 4);

    // Frame 3: 2x2 RGGB, rounding cases, gains arriving on the frame-start cycle
    bayer_pattern = 2'd0;
    h_active_in = 11'd2; v_active_in = 11'd2;
    r_gain_in = 8'd160; g_gain_in = 8'd96; b_gain_in = 8'd255;
    px(8'd100, 1'b1);
    px(8'd3, 1'b0);
    chk("coinc_pend", 16'(gain_pending), 16'd0);
    px(8'd3, 1'b0);
    px(8'd255, 1'b0);
    exp_q = '{125, 2, 2, 255};
    chk_frame("round", 2);

    // Frame 4: gain pulse mid-frame (in a clken gap) must not touch this frame
    px(8'd100, 1'b0);
    @(negedge clk);
    clken = 1'b0;
    r_gain_in = 8'd64; g_gain_in = 8'd128; b_gain_in = 8'd128;
    gain_en = 1'b1;
    @(negedge clk);
    gain_en = 1'b0;
    chk("mid_pend", 16'(gain_pending), 16'd1);
    repeat (3) px(8'd100, 1'b0);
    exp_q = '{125, 75, 75, 199};
    chk_frame("midgain", 2);
    chk("mid_pend_hold", 16'(gain_pending), 16'd1);

    // Frame 5: pending gains commit at pixel (0,0)
    px(8'd100, 1'b0);
    px(8'd100, 1'b0);
    chk("next_pend", 16'(gain_pending), 16'd0);
    repeat (2) px(8'd100, 1'b0);
    exp_q = '{50, 100, 100, 100};
    chk_frame("newgain", 2);

    // Frame 6: bypass gives dout == din regardless of gains
    bypass = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      px(rd, 1'b0);
      exp_q.push_back(int'(rd));
    end
    bypass = 1'b0;
    chk_frame("bypass", 2);

    // Frame 7: reset mid-line drops the pipe; next pixel is a frame start
    h_active_in = 11'd4; v_active_in = 11'd2;
    px(8'd10, 1'b0);
    px(8'd20, 1'b0);
    px(8'd30, 1'b0);
    @(negedge clk);
    clken = 1'b0;
    chk("pre_rst_en", 16'(dout_en), 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_dout", 16'(dout), 16'd0);
    chk("mid_rst_en", 16'(dout_en), 16'd0);
    chk("mid_rst_sof", 16'(dout_sof), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    oq.delete();
    px(8'd77, 1'b0);
    idle(4);
    chk("post_rst_cnt", 16'(oq.size()), 16'd1);
    if (oq.size() > 0) begin
      chk("post_rst_d", 16'(oq[0].d), 16'd77);
      chk("post_rst_sof", 16'(oq[0].s), 16'd1);
      chk("post_rst_eol", 16'(oq[0].e), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
